// File: rtl/load_store_unit.sv
// Load/store unit: turns MEM-stage loads and stores into single bus transactions,
// stalling the pipeline until the response arrives or the access times out.
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] load_data,
    output logic        StallM,
    output logic        misaligned,
    output logic        bus_error,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic          we_q;
    logic [2:0]    funct3_q;
    logic [1:0]    offset_q;

    logic        access;
    logic        illegal;
    logic        unaligned;
    logic        fault;
    logic        issue;
    logic [1:0]  offset;
    logic [31:0] new_wdata;
    logic [3:0]  new_wstrb;
    logic [31:0] lane;
    logic [31:0] extracted;

    assign access    = MemReadM | MemWriteM;
    assign offset    = ALUResultM[1:0];
    assign illegal   = (funct3M == 3'b011) || (funct3M[2:1] == 2'b11);
    assign unaligned = ((funct3M[1:0] == 2'b01) && offset[0]) ||
                       ((funct3M[1:0] == 2'b10) && (offset != 2'b00));
    assign fault     = illegal | unaligned;
    assign issue     = (state == IDLE) && access && !fault;

    // A store wins when both read and write are flagged; loads drive no strobes.
    always_comb begin
        new_wdata = WriteDataM;
        new_wstrb = 4'b1111;
        case (funct3M[1:0])
            2'b00: begin
                new_wdata = {4{WriteDataM[7:0]}};
                new_wstrb = 4'b0001 << offset;
            end
            2'b01: begin
                new_wdata = {2{WriteDataM[15:0]}};
                new_wstrb = 4'b0011 << offset;
            end
            default: begin
                new_wdata = WriteDataM;
                new_wstrb = 4'b1111;
            end
        endcase
        if (!MemWriteM) new_wstrb = 4'b0000;
    end

    assign lane = bus_rdata >> {offset_q, 3'b000};

    always_comb begin
        extracted = lane;
        case (funct3_q)
            3'b000:  extracted = {{24{lane[7]}}, lane[7:0]};
            3'b001:  extracted = {{16{lane[15]}}, lane[15:0]};
            3'b100:  extracted = {24'h000000, lane[7:0]};
            3'b101:  extracted = {16'h0000, lane[15:0]};
            default: extracted = lane;
        endcase
    end

    // The issue cycle presents the request straight from the pipeline inputs;
    // afterwards the latched copy keeps the payload stable.
    assign StallM        = issue || (state == REQ) || (state == WAIT);
    assign bus_req_valid = issue || (state == REQ);
    assign bus_addr      = (state == IDLE) ? {ALUResultM[31:2], 2'b00} : addr_q;
    assign bus_we        = (state == IDLE) ? MemWriteM : we_q;
    assign bus_wdata     = (state == IDLE) ? new_wdata : wdata_q;
    assign bus_wstrb     = (state == IDLE) ? new_wstrb : wstrb_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            load_data  <= 32'h0;
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'b0000;
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            offset_q   <= 2'b00;
        end else begin
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
            case (state)
                IDLE: begin
                    if (access && fault) begin
                        misaligned <= 1'b1;
                        load_data  <= 32'h0;
                    end else if (issue) begin
                        addr_q   <= {ALUResultM[31:2], 2'b00};
                        wdata_q  <= new_wdata;
                        wstrb_q  <= new_wstrb;
                        we_q     <= MemWriteM;
                        funct3_q <= funct3M;
                        offset_q <= offset;
                        count    <= '0;
                        state    <= bus_req_ready ? WAIT : REQ;
                    end
                end
                REQ: begin
                    // The response timeout is measured from acceptance, so restart it here.
                    if (bus_req_ready) begin
                        count <= '0;
                        state <= WAIT;
                    end else if (count == LAST) begin
                        bus_error <= 1'b1;
                        load_data <= 32'h0;
                        state     <= DONE;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                WAIT: begin
                    if (bus_rsp_valid) begin
                        if (!we_q) load_data <= extracted;
                        state <= DONE;
                    end else if (count == LAST) begin
                        bus_error <= 1'b1;
                        load_data <= 32'h0;
                        state     <= DONE;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed corner cases plus random
// accesses, each compared against a lane/byte-level model of the bus protocol.
module tb_load_store_unit;

    localparam int TIMEOUT = 8;

    logic        clk;
    logic        reset;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] load_data;
    logic        StallM;
    logic        misaligned;
    logic        bus_error;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rsp_valid;
    logic [31:0] bus_rdata;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] expLoad;

    load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .load_data(load_data), .StallM(StallM), .misaligned(misaligned),
        .bus_error(bus_error), .bus_req_valid(bus_req_valid),
        .bus_req_ready(bus_req_ready), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int accessBytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic bit isFault(input logic [2:0] f3, input logic [31:0] addr);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
        return (addr % accessBytes(f3)) != 0;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rdata);
        int     n;
        int     off;
        longint v;
        n   = accessBytes(f3);
        off = int'(addr % 4);
        v   = (longint'(rdata) >> (8 * off)) & ((64'd1 << (8 * n)) - 1);
        if (f3[2] == 1'b0 && n < 4 && v >= longint'(64'd1 << (8 * n - 1)))
            v = v - longint'(64'd1 << (8 * n));
        return v[31:0];
    endfunction

    function automatic logic [3:0] modelStrobe(input logic [2:0] f3, input logic [31:0] addr);
        logic [3:0] s;
        int         n;
        int         off;
        n   = accessBytes(f3);
        off = int'(addr % 4);
        s   = 4'b0000;
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + n) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] w;
        int          n;
        n = accessBytes(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
        return w;
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd);
        MemReadM   = rd;
        MemWriteM  = wr;
        funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One MEM-stage access from issue through DONE; the cycle index c counts from
    // the issue cycle, acceptance happens at c == readyDelay and the response
    // arrives rspDelay cycles later (a delay beyond TIMEOUT means no response).
    task automatic runTransaction(input string tag, input logic rd, input logic wr,
                                  input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [31:0] rdata,
                                  input int readyDelay, input int rspDelay);
        bit          timedOut;
        int          doneCycle;
        int          stallCount;
        logic [31:0] doneLoad;
        applyStimulus(rd, wr, f3, addr, wd);
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
        if (isFault(f3, addr)) begin
            @(negedge clk);
            checkOutput({tag, ":stall"}, 32'(StallM), 32'd0);
            checkOutput({tag, ":valid"}, 32'(bus_req_valid), 32'd0);
            nextCycle();
            applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
            expLoad = 32'h0;
            @(negedge clk);
            checkOutput({tag, ":misaligned"}, 32'(misaligned), 32'd1);
            checkOutput({tag, ":load_data"}, load_data, expLoad);
            checkOutput({tag, ":valid_after"}, 32'(bus_req_valid), 32'd0);
            nextCycle();
            @(negedge clk);
            checkOutput({tag, ":misaligned_end"}, 32'(misaligned), 32'd0);
            nextCycle();
        end else begin
            timedOut   = rspDelay > TIMEOUT;
            doneCycle  = readyDelay + (timedOut ? TIMEOUT : rspDelay) + 1;
            doneLoad   = timedOut ? 32'h0 : (wr ? expLoad : modelLoad(f3, addr, rdata));
            stallCount = 0;
            for (int c = 0; c <= doneCycle; c++) begin
                bit respond;
                respond       = !timedOut && (c == readyDelay + rspDelay);
                bus_req_ready = (c >= readyDelay);
                bus_rsp_valid = respond ||
                                ((c <= readyDelay || c == doneCycle) && ($urandom_range(0, 1) == 1));
                bus_rdata     = respond ? rdata : $urandom();
                @(negedge clk);
                if (StallM) stallCount++;
                if (c <= readyDelay) begin
                    checkOutput({tag, ":valid"}, 32'(bus_req_valid), 32'd1);
                    checkOutput({tag, ":addr"}, bus_addr, addr & ~32'h3);
                    checkOutput({tag, ":we"}, 32'(bus_we), 32'(wr));
                    if (wr) begin
                        checkOutput({tag, ":wdata"}, bus_wdata, modelWdata(f3, wd));
                        checkOutput({tag, ":wstrb"}, 32'(bus_wstrb), 32'(modelStrobe(f3, addr)));
                    end
                end else if (c < doneCycle) begin
                    checkOutput({tag, ":wait_valid"}, 32'(bus_req_valid), 32'd0);
                end else begin
                    checkOutput({tag, ":done_stall"}, 32'(StallM), 32'd0);
                    checkOutput({tag, ":done_valid"}, 32'(bus_req_valid), 32'd0);
                    checkOutput({tag, ":bus_error"}, 32'(bus_error), 32'(timedOut));
                    checkOutput({tag, ":load_data"}, load_data, doneLoad);
                end
                nextCycle();
            end
            expLoad = doneLoad;
            applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
            bus_req_ready = 1'b0;
            bus_rsp_valid = 1'b0;
            @(negedge clk);
            checkOutput({tag, ":stall_cycles"}, 32'(stallCount), 32'(doneCycle));
            checkOutput({tag, ":error_end"}, 32'(bus_error), 32'd0);
            checkOutput({tag, ":idle_stall"}, 32'(StallM), 32'd0);
            checkOutput({tag, ":hold"}, load_data, expLoad);
            nextCycle();
        end
    endtask

    // Reset while a load waits for its response; the late response must be dropped.
    task automatic resetInWait();
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_B000, 32'h0);
        bus_req_ready = 1'b1;
        bus_rsp_valid = 1'b0;
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        bus_req_ready = 1'b0;
        reset         = 1'b1;
        @(negedge clk);
        checkOutput("rst_wait:stall", 32'(StallM), 32'd1);
        nextCycle();
        reset         = 1'b0;
        bus_rsp_valid = 1'b1;
        bus_rdata     = 32'hCAFE_F00D;
        expLoad       = 32'h0;
        @(negedge clk);
        checkOutput("rst_wait:stall_after", 32'(StallM), 32'd0);
        checkOutput("rst_wait:valid_after", 32'(bus_req_valid), 32'd0);
        checkOutput("rst_wait:load_data", load_data, expLoad);
        nextCycle();
        bus_rsp_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_wait:no_done", load_data, expLoad);
        checkOutput("rst_wait:idle_stall", 32'(StallM), 32'd0);
        nextCycle();
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
        bus_rdata     = 32'h0;
        reset         = 1'b1;
        expLoad       = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset:stall", 32'(StallM), 32'd0);
        checkOutput("reset:valid", 32'(bus_req_valid), 32'd0);
        checkOutput("reset:misaligned", 32'(misaligned), 32'd0);
        checkOutput("reset:bus_error", 32'(bus_error), 32'd0);
        checkOutput("reset:load_data", load_data, 32'h0);
        nextCycle();

        runTransaction("lb_1003", 1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1, 2);
        runTransaction("sh_2002", 1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 0, 1);
        runTransaction("sw_hold", 1'b0, 1'b1, 3'b010, 32'h0000_4000, 32'hDEAD_BEEF, 32'h0, 5, 1);
        runTransaction("lw_3001", 1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 0, 1);
        runTransaction("lbu_5001", 1'b1, 1'b0, 3'b100, 32'h0000_5001, 32'h0, 32'h1234_9A78, 0, 1);
        runTransaction("illegal", 1'b1, 1'b0, 3'b011, 32'h0000_5000, 32'h0, 32'h0, 0, 1);
        runTransaction("lhu_6002", 1'b1, 1'b0, 3'b101, 32'h0000_6002, 32'h0, 32'h8001_7FFF, 2, 3);
        runTransaction("lw_last", 1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0, 32'h1234_5678, 0, TIMEOUT);
        runTransaction("timeout", 1'b1, 1'b0, 3'b000, 32'h0000_8000, 32'h0, 32'hFFFF_FFFF, 0, 1000);
        runTransaction("lh_9000", 1'b1, 1'b0, 3'b001, 32'h0000_9000, 32'h0, 32'h0000_F00D, 0, 1);
        runTransaction("rd_and_wr", 1'b1, 1'b1, 3'b010, 32'h0000_A000, 32'h1357_9BDF, 32'h0, 0, 1);
        resetInWait();

        for (int t = 0; t < 40; t++) begin
            logic [1:0] kind;
            kind = 2'($urandom_range(1, 3));
            runTransaction($sformatf("rand%0d", t), kind[0], kind[1], 3'($urandom_range(0, 7)),
                           $urandom(), $urandom(), $urandom(),
                           int'($urandom_range(0, 4)), int'($urandom_range(1, TIMEOUT + 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles from request acceptance to response before a bus error is flagged.
REQ-002 SHALL have one clock and a synchronous, active-high reset; ports clk and reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 MemReadM  input  1  MEM-stage instruction is a load.
REQ-006 MemWriteM  input  1  MEM-stage instruction is a store.
REQ-007 funct3M  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 ALUResultM  input  32  byte address.
REQ-009 WriteDataM  input  32  store data, right-aligned.
REQ-010 load_data  output  32  aligned, extended load result.
REQ-011 StallM  output  1  request to the hazard unit to hold IF..MEM and bubble WB.
REQ-012 misaligned  output  1  one-cycle pulse on misaligned or illegal-funct3 access.
REQ-013 bus_error  output  1  one-cycle pulse on response timeout.
REQ-014 bus_req_valid / bus_req_ready  output / input  1 / 1  request handshake.
REQ-015 bus_we  output  1  1 = write.
REQ-016 bus_addr  output  32  word address {ALUResultM[31:2],2'b00}.
REQ-017 bus_wdata / bus_wstrb  output  32 / 4  lane-replicated data, byte strobes.
REQ-018 bus_rsp_valid / bus_rdata  input  1 / 32  response strobe and read word (write ack ignores rdata).

Function
REQ-019 SHALL implement FSM states IDLE, REQ, WAIT, DONE.
REQ-020 IDLE: access = MemReadM|MemWriteM; if access and legal, StallM=1 combinationally, bus_req_valid=1 in the same cycle, next state REQ (or WAIT if bus_req_ready=1 that cycle).
REQ-021 REQ: bus_req_valid held 1, with addr/we/wdata/wstrb stable, until bus_req_ready=1; then WAIT.
REQ-022 WAIT: bus_req_valid=0; on bus_rsp_valid, register the load result and go to DONE.
REQ-023 DONE: lasts exactly one cycle with StallM=0 and load_data valid; then IDLE (the pipeline advances on that edge).
REQ-024 StallM SHALL be 1 in REQ and WAIT and in the IDLE issue cycle, and 0 otherwise.
REQ-025 Responses SHALL be accepted no earlier than the cycle after request acceptance; bus_rsp_valid in IDLE, REQ, or DONE SHALL be ignored.
REQ-026 Store lanes: SB wstrb=4'b0001<<addr[1:0], wdata={4{byte}}; SH wstrb=4'b0011<<addr[1:0], wdata={2{half}}; SW wstrb=4'b1111.
REQ-027 Load extract: the lane is selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
REQ-028 Misaligned: H with addr[0]=1, or W with addr[1:0]!=0; funct3 011/110/111 is illegal. SHALL raise misaligned for 1 cycle, issue no bus request, leave StallM=0, and set load_data=0.
REQ-029 The timeout counter SHALL reset on entry to REQ and count in REQ and WAIT. On reaching TIMEOUT it SHALL pulse bus_error, set load_data=0, and go to DONE.
REQ-030 Both MemReadM and MemWriteM set SHALL be treated as a store.
REQ-031 load_data SHALL hold its value outside DONE until the next completed load.

Reset
REQ-032 On reset: state=IDLE, bus_req_valid=0, StallM=0, misaligned=0, bus_error=0, load_data=0, counter=0.
REQ-033 Reset mid-transaction SHALL abort it; a late response after reset SHALL be ignored.

Verification
REQ-034 LB, addr 0x1003, bus_rdata 0x80FF_1234, rsp 2 cycles after accept -> bus_addr 0x1000; load_data 0xFFFF_FF80 in DONE; StallM high 4 cycles.
REQ-035 SH, addr 0x2002, WriteDataM 0x0000_ABCD -> bus_wstrb 4'b1100, bus_wdata 0xABCD_ABCD, bus_we=1.
REQ-036 bus_req_ready held 0 for 5 cycles -> bus_req_valid and payload stable all 5 cycles; a single request is accepted.
REQ-037 LW at 0x3001 -> misaligned pulse 1 cycle, bus_req_valid never 1, StallM=0.
REQ-038 TIMEOUT=8, no response -> bus_error pulses 8 cycles after accept, DONE, then IDLE.
REQ-039 reset in WAIT, then bus_rsp_valid next cycle -> state IDLE, load_data=0, no DONE.
